// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if -- one requester's port into the VRAM arbiter.
//
// Signals (direction given from the requester's point of view):
//   valid  out  request present; held with we/addr/wdata until handshake
//   ready  in   request accepted this cycle (valid && ready = handshake)
//   we     out  1 = write, 0 = read
//   addr   out  32-bit word address
//   wdata  out  32-bit write data
//   rvalid in   read data valid (exactly one cycle per read)
//   rdata  in   read data; holds its last value while rvalid is low
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vram_req_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter -- two-port round-robin arbiter onto a single-port VRAM.
//
// Requester 0 is the CPU, requester 1 the DMA/init sequencer. CPU writes that
// land in the sprite/BG parameter region are held off until vblank so the
// renderer never sees a half-updated parameter set; the DMA keeps flowing
// while the CPU waits.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   vblank     in   high while the display is outside the active area
//   req0       slave  CPU request port      (vram_req_if)
//   req1       slave  DMA request port      (vram_req_if)
//   mem_en     out  memory access strobe (one cycle after the handshake)
//   mem_we     out  memory write enable
//   mem_addr   out  memory word address (holds between accesses)
//   mem_din    out  write data to memory (holds between accesses)
//   mem_dout   in   read data, valid the cycle after a mem_en read
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter logic [31:0] PARAM_BASE  = 32'h0600_0000,
    parameter int unsigned PARAM_WORDS = 660
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblank,
    vram_req_if.slave        req0,
    vram_req_if.slave        req1,
    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout
);

    typedef enum logic {
        ID_CPU = 1'b0,
        ID_DMA = 1'b1
    } req_id_t;

    // One slot of the read-return pipeline: is it a read, and whose.
    typedef struct packed {
        logic    rd;
        req_id_t id;
    } rd_tag_t;

    localparam logic [31:0] PARAM_END = PARAM_BASE + PARAM_WORDS;

    req_id_t     last_grant;
    logic        blocked0;
    logic        grant0;
    logic        grant1;
    logic        hs;
    req_id_t     win_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic        mem_en_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    rd_tag_t     tag_s1;
    rd_tag_t     tag_s2;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    // Eligibility, round-robin pick and request mux.
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned (which would infer a latch).
    always_comb begin
        blocked0  = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        win_id    = ID_CPU;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;

        blocked0 = req0.we && !vblank &&
                   (req0.addr >= PARAM_BASE) && (req0.addr < PARAM_END);

        if (!rst) begin
            if ((req0.valid && !blocked0) && req1.valid) begin
                // Tie: whoever did not win last time goes now.
                if (last_grant == ID_CPU) grant1 = 1'b1;
                else                      grant0 = 1'b1;
            end else if (req0.valid && !blocked0) begin
                grant0 = 1'b1;
            end else if (req1.valid) begin
                grant1 = 1'b1;
            end
        end

        if (grant1) begin
            win_id    = ID_DMA;
            sel_we    = req1.we;
            sel_addr  = req1.addr;
            sel_wdata = req1.wdata;
        end else begin
            sel_we    = req0.we;
            sel_addr  = req0.addr;
            sel_wdata = req0.wdata;
        end
    end

    // A grant is only ever raised against a present valid, so any grant is a handshake.
    assign hs = grant0 || grant1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= ID_DMA;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tag_s1     <= '0;
            tag_s2     <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            mem_en_q <= hs;
            mem_we_q <= hs && sel_we;
            if (hs) begin
                last_grant <= win_id;
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_wdata;
            end
            // Stage 1 lines up with mem_en, stage 2 with mem_dout.
            tag_s1 <= '{rd: hs && !sel_we, id: win_id};
            tag_s2 <= tag_s1;
            if (rvalid0) rdata0_q <= mem_dout;
            if (rvalid1) rdata1_q <= mem_dout;
        end
    end

    assign rvalid0 = !rst && tag_s2.rd && (tag_s2.id == ID_CPU);
    assign rvalid1 = !rst && tag_s2.rd && (tag_s2.id == ID_DMA);

    assign req0.ready  = grant0;
    assign req1.ready  = grant1;
    assign req0.rvalid = rvalid0;
    assign req1.rvalid = rvalid1;

    // Read data passes straight through on the return cycle and is then held,
    // so the requester sees it in the rvalid cycle itself.
    assign req0.rdata = rst ? '0 : (rvalid0 ? mem_dout : rdata0_q);
    assign req1.rdata = rst ? '0 : (rvalid1 ? mem_dout : rdata1_q);

    // Outputs are forced quiet for the whole reset window, including the
    // first reset cycle before the registers have been cleared.
    assign mem_en   = mem_en_q && !rst;
    assign mem_we   = mem_we_q && !rst;
    assign mem_addr = rst ? '0 : mem_addr_q;
    assign mem_din  = rst ? '0 : mem_din_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter -- directed bench for vram_arbiter.
// Inputs change 1 ns after a rising edge; ready is sampled 1 ns after that,
// registered outputs 1 ns after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;

    int n_cmp;
    int n_err;

    logic [31:0] a0, d0, a1, d1, ea, ed;
    logic        exp_dma;

    vram_req_if req0_bus ();
    vram_req_if req1_bus ();

    vram_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .vblank   (vblank),
        .req0     (req0_bus),
        .req1     (req1_bus),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: one special word, everything else a fixed function of address.
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a == 32'h0630_0100) ? 32'hFF00_00FF : (a ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_dout <= model_rd(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        req0_bus.valid = v;
        req0_bus.we    = we;
        req0_bus.addr  = a;
        req0_bus.wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        req1_bus.valid = v;
        req1_bus.we    = we;
        req1_bus.addr  = a;
        req1_bus.wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        vblank = 1'b1;

        // ---- reset with requests present: nothing may be granted ----
        set0(1'b1, 1'b1, 32'h0000_1000, 32'hD000_0000);
        set1(1'b1, 1'b1, 32'h0610_0000, 32'hE000_0000);
        step();
        step();
        check("rst_ready0",  req0_bus.ready,  0);
        check("rst_ready1",  req1_bus.ready,  0);
        check("rst_mem_en",  mem_en,          0);
        check("rst_mem_we",  mem_we,          0);
        check("rst_mem_addr", mem_addr,       0);
        check("rst_mem_din", mem_din,         0);
        check("rst_rvalid0", req0_bus.rvalid, 0);
        check("rst_rvalid1", req1_bus.rvalid, 0);
        check("rst_rdata0",  req0_bus.rdata,  0);
        check("rst_rdata1",  req1_bus.rdata,  0);

        // ---- both writing, vblank high: grants alternate 0,1,0,1 ----
        rst = 1'b0;
        a0 = 32'h0000_1000; d0 = 32'hD000_0000;
        a1 = 32'h0610_0000; d1 = 32'hE000_0000;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_dma = (k % 2 == 1);
            check("rr_ready0", req0_bus.ready, !exp_dma);
            check("rr_ready1", req1_bus.ready, exp_dma);
            ea = exp_dma ? a1 : a0;
            ed = exp_dma ? d1 : d0;
            step();
            check("rr_mem_en",   mem_en,   1);
            check("rr_mem_we",   mem_we,   1);
            check("rr_mem_addr", mem_addr, ea);
            check("rr_mem_din",  mem_din,  ed);
            if (exp_dma) begin
                a1 = a1 + 1; d1 = d1 + 1;
                set1(1'b1, 1'b1, a1, d1);
            end else begin
                a0 = a0 + 1; d0 = d0 + 1;
                set0(1'b1, 1'b1, a0, d0);
            end
            #1;
        end

        // ---- idle cycle: strobe drops, address and data hold ----
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("idle_mem_en",   mem_en,   0);
        check("idle_mem_we",   mem_we,   0);
        check("idle_mem_addr", mem_addr, 32'h0610_0001);
        check("idle_mem_din",  mem_din,  32'hE000_0001);

        // ---- CPU param write held until vblank rises ----
        vblank = 1'b0;
        set0(1'b1, 1'b1, 32'h0600_0005, 32'hC0DE_0005);
        #1;
        for (int i = 0; i < 9; i++) begin
            check("blk_ready0", req0_bus.ready, 0);
            step();
            check("blk_mem_en", mem_en, 0);
        end
        vblank = 1'b1;
        #1;
        check("vbl_ready0", req0_bus.ready, 1);
        step();
        check("vbl_mem_en",   mem_en,   1);
        check("vbl_mem_we",   mem_we,   1);
        check("vbl_mem_addr", mem_addr, 32'h0600_0005);
        check("vbl_mem_din",  mem_din,  32'hC0DE_0005);

        // ---- blocked CPU does not stall DMA ----
        vblank = 1'b0;
        set0(1'b1, 1'b1, 32'h0600_0010, 32'hC0DE_0010);
        for (int k = 0; k < 4; k++) begin
            set1(1'b1, 1'b1, 32'h0610_0000 + k, 32'hB000_0000 + k);
            #1;
            check("dma_ready1", req1_bus.ready, 1);
            check("dma_ready0", req0_bus.ready, 0);
            step();
            check("dma_mem_en",   mem_en,   1);
            check("dma_mem_addr", mem_addr, 32'h0610_0000 + k);
            check("dma_mem_din",  mem_din,  32'hB000_0000 + k);
        end
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("dma_done_ready0", req0_bus.ready, 0);

        // ---- region boundaries with vblank low ----
        set0(1'b1, 1'b1, 32'h0600_0293, 32'h1111_0293);
        #1;
        check("last_word_ready0", req0_bus.ready, 0);
        set0(1'b1, 1'b1, 32'h05FF_FFFF, 32'h1111_FFFF);
        #1;
        check("below_ready0", req0_bus.ready, 1);
        step();
        check("below_mem_addr", mem_addr, 32'h05FF_FFFF);
        set0(1'b1, 1'b1, 32'h0600_0294, 32'h1111_0294);
        #1;
        check("above_ready0", req0_bus.ready, 1);
        step();
        check("above_mem_addr", mem_addr, 32'h0600_0294);
        check("above_mem_din",  mem_din,  32'h1111_0294);
        // Reads inside the region are never held.
        set0(1'b1, 1'b0, 32'h0600_0001, 32'h0);
        #1;
        check("prd_ready0", req0_bus.ready, 1);
        step();
        check("prd_mem_en", mem_en, 1);
        check("prd_mem_we", mem_we, 0);
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("prd_rvalid0", req0_bus.rvalid, 1);
        check("prd_rdata0",  req0_bus.rdata,  32'hA3A5_0001);

        // ---- DMA read: rvalid exactly at T+2 ----
        set1(1'b1, 1'b0, 32'h0630_0100, 32'h0);
        #1;
        check("rd1_ready1", req1_bus.ready, 1);
        step();
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        check("rd1_mem_en",   mem_en,          1);
        check("rd1_mem_we",   mem_we,          0);
        check("rd1_mem_addr", mem_addr,        32'h0630_0100);
        check("rd1_early",    req1_bus.rvalid, 0);
        step();
        check("rd1_rvalid1", req1_bus.rvalid, 1);
        check("rd1_rdata1",  req1_bus.rdata,  32'hFF00_00FF);
        check("rd1_rvalid0", req0_bus.rvalid, 0);
        step();
        check("rd1_late",       req1_bus.rvalid, 0);
        check("rd1_rdata_hold", req1_bus.rdata,  32'hFF00_00FF);

        // ---- two reads in flight back to back ----
        set0(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        #1;
        check("b2b_ready0", req0_bus.ready, 1);
        step();
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b1, 1'b0, 32'h0630_0200, 32'h0);
        #1;
        check("b2b_ready1", req1_bus.ready, 1);
        step();
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_mem_en",  mem_en,          1);
        check("b2b_rvalid0", req0_bus.rvalid, 1);
        check("b2b_rdata0",  req0_bus.rdata,  32'hA5A5_0040);
        check("b2b_quiet1",  req1_bus.rvalid, 0);
        step();
        check("b2b_rvalid1",     req1_bus.rvalid, 1);
        check("b2b_rdata1",      req1_bus.rdata,  32'hA395_0200);
        check("b2b_quiet0",      req0_bus.rvalid, 0);
        check("b2b_rdata0_hold", req0_bus.rdata,  32'hA5A5_0040);

        // ---- reset one cycle after a read handshake drops the read ----
        set0(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        #1;
        check("rrst_ready0", req0_bus.ready, 1);
        step();
        rst = 1'b1;
        set0(1'b1, 1'b1, 32'h0000_1000, 32'h5);
        #1;
        check("rrst_ready0_in_rst", req0_bus.ready, 0);
        check("rrst_mem_en",   mem_en,          0);
        check("rrst_mem_addr", mem_addr,        0);
        check("rrst_rdata0",   req0_bus.rdata,  0);
        check("rrst_rdata1",   req1_bus.rdata,  0);
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("rrst_no_rvalid0", req0_bus.rvalid, 0);
        check("rrst_after_en",   mem_en,          0);
        check("rrst_after_rd0",  req0_bus.rdata,  0);
        step();
        check("rrst_still_none", req0_bus.rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
